// File: rtl/modmul_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : modmul_controller_if
// Brief    : Request/response bundle between the exponent loop and the
//            modular-multiply sequencer (operands in, result/status out).
// Revision : 1.0 - initial release
// ============================================================================
interface modmul_controller_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] n;
    logic         busy;
    logic         done;
    logic         err;
    logic [N-1:0] result;

    // Requester side: issues operands, observes status and result
    modport master (
        output start, a, b, n,
        input  busy, done, err, result
    );

    // Sequencer side
    modport slave (
        input  start, a, b, n,
        output busy, done, err, result
    );
endinterface
`default_nettype wire

// File: rtl/modmul_controller.sv
`default_nettype none
// ============================================================================
// Module   : modmul_controller
// Brief    : Computes (a*b) mod n by interleaved shift-add, one ALU operation
//            per cycle, driving the shared EX-stage operand mux and ALU.
//            Optional macro MODMUL_SKIP_LZ_EN: start the bit scan at the MSB
//            set in b and finish immediately when b==0.
// Revision : 1.0 - initial release
// ============================================================================
module modmul_controller #(
    parameter int N = 32
) (
    input  wire               clk,
    input  wire               rst,
    modmul_controller_if.slave bus,
    output logic [N-1:0]      rda,
    output logic [N-1:0]      rdb,
    output logic [N-1:0]      extended,
    output logic              alu_func,
    output logic              opb_selector,
    input  wire  [N-1:0]      alu_result,
    input  wire               C,
    input  wire               Z
);
    localparam int          IW      = (N > 1) ? $clog2(N) : 1;
    localparam [IW-1:0]     C_I_TOP = IW'(N - 1);
    localparam [IW-1:0]     C_I_ONE = IW'(1);

    localparam [2:0] S_IDLE    = 3'd0;
    localparam [2:0] S_DBL     = 3'd1;
    localparam [2:0] S_DBL_RED = 3'd2;
    localparam [2:0] S_ADD     = 3'd3;
    localparam [2:0] S_ADD_RED = 3'd4;
    localparam [2:0] S_DONE    = 3'd5;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_n;
    logic [N-1:0]  r_r;
    logic [N-1:0]  r_tmp;
    logic          r_cy;
    logic [IW-1:0] r_i;
    logic [N-1:0]  r_result;
    logic          r_err;
    logic [IW-1:0] w_i_load;
    logic [N-1:0]  w_red_r;
    logic          w_b_zero;

    // The zero flag has no role in the multiply sequence itself
    wire w_unused_z = Z;

    // Reduction step: keep the subtracted value when the doubled/added value
    // reached n (either it overflowed N bits, or the subtract did not borrow).
    // A wrapped subtract after overflow lands on the correct residue.
    assign w_red_r = (r_cy | C) ? alu_result : r_tmp;

    assign bus.err    = r_err;
    assign bus.result = r_result;

    // Starting bit index for a new request
    always_comb begin
        w_i_load = C_I_TOP;
        w_b_zero = 1'b0;
`ifdef MODMUL_SKIP_LZ_EN
        w_i_load = '0;
        w_b_zero = (bus.b == '0);
        for (int k = 0; k < N; k++) begin
            if (bus.b[k]) begin
                w_i_load = IW'(k);
            end
        end
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: one DBL/DBL_RED pair per bit of b, plus ADD/ADD_RED per set bit
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.n == '0 || w_b_zero) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_DBL;
                    end
                end
            end
            S_DBL:     w_state_nxt = S_DBL_RED;
            S_DBL_RED: begin
                if (r_b[r_i]) begin
                    w_state_nxt = S_ADD;
                end else if (r_i == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DBL;
                end
            end
            S_ADD:     w_state_nxt = S_ADD_RED;
            S_ADD_RED: w_state_nxt = (r_i == '0) ? S_DONE : S_DBL;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Operand latching, accumulator updates, bit index and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_n      <= '0;
            r_r      <= '0;
            r_tmp    <= '0;
            r_cy     <= 1'b0;
            r_i      <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a   <= bus.a;
                        r_b   <= bus.b;
                        r_n   <= bus.n;
                        r_r   <= '0;
                        r_i   <= w_i_load;
                        r_err <= (bus.n == '0);
                        if (w_state_nxt == S_DONE) begin
                            r_result <= '0;
                        end
                    end
                end
                S_DBL, S_ADD: begin
                    r_tmp <= alu_result;
                    r_cy  <= C;
                end
                S_DBL_RED, S_ADD_RED: begin
                    r_r <= w_red_r;
                    if (w_state_nxt == S_DONE) begin
                        r_result <= w_red_r;
                    end else if (w_state_nxt == S_DBL) begin
                        r_i <= r_i - C_I_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ALU drives and status, decoded from the current state
    always_comb begin
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        rda          = '0;
        rdb          = '0;
        extended     = '0;
        alu_func     = 1'b0;
        opb_selector = 1'b0;
        case (r_state)
            S_DBL: begin
                bus.busy = 1'b1;
                rda      = r_r;
                rdb      = r_r;
                extended = r_n;
            end
            S_ADD: begin
                bus.busy = 1'b1;
                rda      = r_r;
                rdb      = r_a;
                extended = r_n;
            end
            S_DBL_RED, S_ADD_RED: begin
                bus.busy     = 1'b1;
                rda          = r_tmp;
                extended     = r_n;
                alu_func     = 1'b1;
                opb_selector = 1'b1;
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_modmul_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_modmul_controller
// Brief    : Randomised scoreboard bench for modmul_controller with a
//            behavioural ALU and an arithmetic reference model.
//            Honours MODMUL_SKIP_LZ_EN for the latency model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modmul_controller;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    modmul_controller_if #(.N(N)) bus ();

    logic [N-1:0] rda, rdb, extended, alu_result, opb;
    logic [N:0]   sum;
    logic         alu_func, opb_selector, C, Z;

    modmul_controller #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .rda          (rda),
        .rdb          (rdb),
        .extended     (extended),
        .alu_func     (alu_func),
        .opb_selector (opb_selector),
        .alu_result   (alu_result),
        .C            (C),
        .Z            (Z)
    );

    // Behavioural EX-stage ALU with operand mux
    always_comb begin
        opb = opb_selector ? extended : rdb;
        sum = {1'b0, rda} + {1'b0, opb};
        if (alu_func) begin
            alu_result = rda - opb;
            C          = (rda >= opb);
        end else begin
            alu_result = sum[N-1:0];
            C          = sum[N];
        end
        Z = (alu_result == '0);
    end

    typedef struct {
        logic [N-1:0] res;
        logic         err;
        int           lat;
        int           acc;
        logic [N-1:0] n;
    } exp_t;

    exp_t q[$];
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    int n_issued = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: plain modular arithmetic and latency from bit counts
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] n);
        exp_t e;
        int   pc;
        int   msb;
        pc    = $countones(b);
        msb   = -1;
        for (int k = 0; k < N; k++) if (b[k]) msb = k;
        e.n   = n;
        e.acc = 0;
        if (n == '0) begin
            e.res = '0;
            e.err = 1'b1;
            e.lat = 0;
        end else begin
            e.res = N'((longint'(a) * longint'(b)) % longint'(n));
            e.err = 1'b0;
`ifdef MODMUL_SKIP_LZ_EN
            e.lat = (b == '0) ? 0 : 2 * (msb + 1) + 2 * pc;
`else
            e.lat = 2 * N + 2 * pc;
`endif
        end
        return e;
    endfunction

    task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic [N-1:0] in_);
        exp_t e;
        int   w;
        w = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("idle_wait_timeout", (w >= 300), 0);
        bus.a     = ia;
        bus.b     = ib;
        bus.n     = in_;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e     = model(ia, ib, in_);
        e.acc = cyc;
        q.push_back(e);
        n_issued++;
        chk("busy_after_accept", bus.busy, (e.lat > 0));
        bus.a = N'($urandom);
        bus.b = N'($urandom);
        bus.n = N'($urandom);
    endtask

    // Monitor: ALU drive sequence while busy, idle drives, and result scoreboard
    initial begin
        bit   ph;
        exp_t e;
        ph = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ph = 1'b0;
            end else begin
                if (bus.busy) begin
                    chk("opb_selector_seq", opb_selector, ph);
                    chk("alu_func_seq", alu_func, ph);
                    if (q.size() > 0) chk("extended_is_n", extended, q[0].n);
                    ph = ~ph;
                end else begin
                    ph = 1'b0;
                    if (!bus.done)
                        chk("idle_drives_zero", {rda, rdb, extended, alu_func, opb_selector}, 0);
                end
                if (bus.done) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = q.pop_front();
                        n_done++;
                        chk("result", bus.result, e.res);
                        chk("err", bus.err, e.err);
                        chk("latency", cyc - e.acc, e.lat);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.n     = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_result", bus.result, 0);
        chk("reset_drives", {rda, rdb, extended, alu_func, opb_selector}, 0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Directed cases
        issue(8'd5, 8'd7, 8'd13);
        issue(8'd200, 8'd250, 8'd251);
        issue(8'd9, 8'd0, 8'd13);
        issue(8'd77, 8'd123, 8'd0);

        // Asynchronous reset in the ADD state of the first set bit
        issue(8'd5, 8'h81, 8'd13);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("add_state_rdb", rdb, 5);
        chk("add_state_sel", opb_selector, 0);
        rst = 1'b1;
        q.delete();
        n_issued--;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_err", bus.err, 0);
        chk("midrst_result", bus.result, 0);
        chk("midrst_drives", {rda, rdb, extended, alu_func, opb_selector}, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        issue(8'd3, 8'd4, 8'd7);

        // start held high with changing operands while busy and through DONE
        issue(8'd9, 8'd77, 8'd101);
        bus.start = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            bus.a = N'($urandom);
            bus.b = N'($urandom);
            bus.n = N'($urandom);
            w++;
        end while (!bus.done && w < 300);
        chk("pulse_done_timeout", (w >= 300), 0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pulse_no_accept_busy", bus.busy, 0);
        chk("pulse_no_accept_done", bus.done, 0);

        // Randomised requests
        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] rn, ra, rb;
            rn = ($urandom_range(0, 9) == 0) ? '0 : N'($urandom_range(1, (1 << N) - 1));
            ra = (rn == '0) ? N'($urandom) : N'($urandom_range(0, int'(rn) - 1));
            rb = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            issue(ra, rb, rn);
        end

        w = 0;
        while (q.size() > 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("drain_pending", q.size(), 0);
        chk("done_count", n_done, n_issued);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
